sobel_edge_engine: RTL and testbench

SOBEL_EDGE_ENGINE -- requirements
Module: sobel_edge_engine

---
 rtl/sobel_edge_engine.sv | 196 +++++++++++++++++++
 tb/tb_sobel_edge_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_engine.sv
// Streaming 3x3 Sobel edge detector: reads a frame column by column through a
// latency-RD_LAT memory port and writes a one-bit edge map in raster order.
module sobel_edge_engine #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int PIX_W     = 10,
    parameter int PIX_LSB   = 20,
    parameter int ADDR_W    = 19,
    parameter int RD_LAT    = 1,
    parameter int SQ_SHIFT  = 16,
    parameter int ABS_SHIFT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [6:0]        thres,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [35:0]       read_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_data,
    output logic              write_en,
    output logic              busy,
    output logic              done
);

    localparam int P    = RD_LAT + 5;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int RW   = $clog2(HEIGHT + 1);
    localparam int SW   = $clog2(P);
    localparam int GW   = PIX_W + 3;
    localparam int CMPW = 2 * GW + 9 + SQ_SHIFT + ABS_SHIFT;

    localparam logic [CW-1:0]     COL_LAST = CW'(WIDTH);
    localparam logic [RW-1:0]     ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [SW-1:0]     CYC_LAST = SW'(P - 1);
    localparam logic [SW-1:0]     CYC_WR   = SW'(P - 2);
    localparam logic [SW-1:0]     CYC_CAP0 = SW'(RD_LAT);
    localparam logic [SW-1:0]     CYC_CAP1 = SW'(RD_LAT + 1);
    localparam logic [SW-1:0]     CYC_CAP2 = SW'(RD_LAT + 2);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t                        state_q, state_d;
    logic [SW-1:0]                 cyc_q;
    logic [CW-1:0]                 col_q;
    logic [RW-1:0]                 row_q;
    logic [ADDR_W-1:0]             row_base_q;
    logic [1:0]                    mode_q;
    logic [6:0]                    thres_q;
    logic [2:0][2:0][PIX_W-1:0]    win_q;   // [row][col], col 2 is newest
    logic [PIX_W-1:0]              top_q, mid_q;
    logic                          write_en_q, write_data_q;
    logic [ADDR_W-1:0]             write_addr_q;

    logic              step_end, last_step, in_col, up_ok, dn_ok, wr_fire, hit;
    logic [PIX_W-1:0]  pix, tap_top, tap_mid, tap_bot;
    logic signed [GW-1:0] gx, gy;
    logic              unused_rd;

    function automatic logic signed [GW-1:0] px(input logic [PIX_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic [CMPW-1:0] mag(input logic signed [GW-1:0] v);
        logic [GW-1:0] a;
        a = v[GW-1] ? -v : v;
        return CMPW'(a);
    endfunction

    function automatic logic edge_hit(input logic [1:0] m, input logic [6:0] t,
                                      input logic signed [GW-1:0] vx,
                                      input logic signed [GW-1:0] vy);
        logic [CMPW-1:0] ax, ay, t_sq, t_abs;
        ax    = mag(vx);
        ay    = mag(vy);
        t_sq  = CMPW'(t) << SQ_SHIFT;
        t_abs = CMPW'(t) << ABS_SHIFT;
        case (m)
            2'd0:    return (ax * ax + ay * ay) > t_sq;
            2'd1:    return ax > t_abs;
            2'd2:    return ay > t_abs;
            default: return (ax + ay) > t_abs;
        endcase
    endfunction

    assign step_end  = (state_q == S_RUN) && (cyc_q == CYC_LAST);
    assign last_step = step_end && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign in_col    = (col_q != COL_LAST);
    assign up_ok     = (row_q != '0);
    assign dn_ok     = (row_q != ROW_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (abort) state_d = S_IDLE;
                      else if (last_step) state_d = S_FINISH;
                      default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FINISH);

    // Rows y-1, y, y+1 of column k on step cycles 0..2; out-of-image taps park at 0.
    always_comb begin
        read_addr = '0;
        if (state_q == S_RUN && in_col) begin
            if (cyc_q == SW'(0) && up_ok)      read_addr = row_base_q - ROW_STEP + ADDR_W'(col_q);
            else if (cyc_q == SW'(1))          read_addr = row_base_q + ADDR_W'(col_q);
            else if (cyc_q == SW'(2) && dn_ok) read_addr = row_base_q + ROW_STEP + ADDR_W'(col_q);
        end
    end

    assign pix       = read_data[PIX_LSB +: PIX_W];
    assign unused_rd = ^read_data;
    assign tap_top   = (in_col && up_ok) ? pix : '0;
    assign tap_mid   = in_col ? pix : '0;
    assign tap_bot   = (in_col && dn_ok) ? pix : '0;

    assign gx = (px(win_q[0][2]) + (px(win_q[1][2]) <<< 1) + px(win_q[2][2]))
              - (px(win_q[0][0]) + (px(win_q[1][0]) <<< 1) + px(win_q[2][0]));
    assign gy = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
              - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
    assign hit     = edge_hit(mode_q, thres_q, gx, gy);
    assign wr_fire = (state_q == S_RUN) && !abort && (cyc_q == CYC_WR) && (col_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            mode_q       <= '0;
            thres_q      <= '0;
            win_q        <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            write_en_q   <= 1'b0;
            write_data_q <= 1'b0;
            write_addr_q <= '0;
        end else begin
            write_en_q   <= wr_fire;
            write_data_q <= wr_fire & hit;
            if (wr_fire) write_addr_q <= row_base_q + ADDR_W'(col_q) - ADDR_W'(1);

            if (state_q == S_IDLE && start) begin
                cyc_q      <= '0;
                col_q      <= '0;
                row_q      <= '0;
                row_base_q <= '0;
                mode_q     <= mode;
                thres_q    <= thres;
            end else if (state_q == S_RUN) begin
                if (step_end) begin
                    cyc_q <= '0;
                    if (col_q == COL_LAST) begin
                        col_q      <= '0;
                        row_q      <= row_q + RW'(1);
                        row_base_q <= row_base_q + ROW_STEP;
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end else begin
                    cyc_q <= cyc_q + SW'(1);
                end

                if (cyc_q == CYC_CAP0) top_q <= tap_top;
                if (cyc_q == CYC_CAP1) mid_q <= tap_mid;
                // Column -1 is zero at row start, so the older columns are flushed at k=0.
                if (cyc_q == CYC_CAP2) begin
                    for (int r = 0; r < 3; r++) begin
                        win_q[r][0] <= (col_q == '0) ? '0 : win_q[r][1];
                        win_q[r][1] <= (col_q == '0) ? '0 : win_q[r][2];
                    end
                    win_q[0][2] <= top_q;
                    win_q[1][2] <= mid_q;
                    win_q[2][2] <= tap_bot;
                end
            end
        end
    end

    assign write_en   = write_en_q;
    assign write_data = write_data_q;
    assign write_addr = write_addr_q;

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Bench for sobel_edge_engine: small frame, latency-2 memory model, and a
// direct-arithmetic Sobel reference.
module tb_sobel_edge_engine;

    localparam int W = 4, H = 3, PW = 10, PLSB = 20, AW = 19, RDL = 2, SQS = 16, ABSS = 5;
    localparam int P = RDL + 5, NPIX = W * H, RUNCYC = H * (W + 1) * P;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [1:0]    mode;
    logic [6:0]    thres;
    logic [AW-1:0] read_addr, write_addr;
    logic [35:0]   read_data;
    logic          write_data, write_en, busy, done;

    always #5 clk = ~clk;

    sobel_edge_engine #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(PW), .PIX_LSB(PLSB), .ADDR_W(AW),
        .RD_LAT(RDL), .SQ_SHIFT(SQS), .ABS_SHIFT(ABSS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mode(mode), .thres(thres),
        .read_addr(read_addr), .read_data(read_data),
        .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
        .busy(busy), .done(done)
    );

    int          img [NPIX];
    logic [35:0] memw [NPIX];
    logic [35:0] rd_pipe [RDL];

    always @(posedge clk) begin
        rd_pipe[0] <= (int'(read_addr) < NPIX) ? memw[read_addr] : '1;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign read_data = rd_pipe[RDL-1];

    int wq_addr[$];
    int wq_data[$];
    int done_cnt = 0, run_cyc = 0;

    always @(negedge clk) begin
        if (write_en) begin
            wq_addr.push_back(int'(write_addr));
            wq_data.push_back(int'(write_data));
        end
        if (done) done_cnt++;
        if (busy && !done) run_cyc++;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_mem();
        logic [35:0] w;
        for (int i = 0; i < NPIX; i++) begin
            w[31:0]        = $urandom();
            w[35:32]       = 4'($urandom());
            w[PLSB +: PW]  = PW'(img[i]);
            memw[i]        = w;
        end
    endtask

    function automatic int pix(int x, int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
        return img[y*W + x];
    endfunction

    function automatic int ref_edge(int x, int y, int m, int t);
        longint gx, gy, ax, ay, lim_sq, lim_abs;
        gx = (pix(x+1, y-1) + 2*pix(x+1, y) + pix(x+1, y+1))
           - (pix(x-1, y-1) + 2*pix(x-1, y) + pix(x-1, y+1));
        gy = (pix(x-1, y+1) + 2*pix(x, y+1) + pix(x+1, y+1))
           - (pix(x-1, y-1) + 2*pix(x, y-1) + pix(x+1, y-1));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        lim_sq  = longint'(t) * (64'd1 << SQS);
        lim_abs = longint'(t) * (64'd1 << ABSS);
        case (m)
            0:       return (gx*gx + gy*gy > lim_sq) ? 1 : 0;
            1:       return (ax > lim_abs) ? 1 : 0;
            2:       return (ay > lim_abs) ? 1 : 0;
            default: return (ax + ay > lim_abs) ? 1 : 0;
        endcase
    endfunction

    task automatic begin_frame(input int m, input int t);
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        run_cyc  = 0;
        mode  = 2'(m);
        thres = 7'(t);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < RUNCYC + 50) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, longint'(done_cnt > 0), 1);
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag, input int m, input int t);
        chk({tag, "_nwr"}, wq_addr.size(), NPIX);
        for (int i = 0; i < wq_addr.size() && i < NPIX; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
            chk($sformatf("%s_data%0d", tag, i), wq_data[i], ref_edge(i % W, i / W, m, t));
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_run_cyc"}, run_cyc, RUNCYC);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic full_frame(input string tag, input int m, input int t);
        begin_frame(m, t);
        wait_done(tag);
        check_frame(tag, m, t);
    endtask

    task automatic rand_img();
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 1023);
        build_mem();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; thres = '0;
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        build_mem();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", write_en, 0);
        chk("rst_wd", write_data, 0);
        chk("rst_ra", read_addr, 0);
        chk("rst_wa", write_addr, 0);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < NPIX; i++) img[i] = 512;
        build_mem();
        full_frame("flat", 0, 0);

        for (int i = 0; i < NPIX; i++) img[i] = (i % W >= 2) ? 1023 : 0;
        build_mem();
        full_frame("cols", 1, 127);
        if (wq_data.size() == NPIX) begin
            chk("cols_x1y1", wq_data[5], 1);
            chk("cols_x2y1", wq_data[6], 1);
            chk("cols_x1y0", wq_data[1], 0);
            chk("cols_x2y2", wq_data[10], 0);
        end

        for (int i = 0; i < NPIX; i++) img[i] = 0;
        img[1*W + 2] = 256;
        build_mem();
        full_frame("pt_t2", 0, 2);
        if (wq_data.size() == NPIX) chk("pt_t2_x1y0", wq_data[1], 0);
        full_frame("pt_t1", 0, 1);
        if (wq_data.size() == NPIX) chk("pt_t1_x1y0", wq_data[1], 1);

        for (int f = 0; f < 8; f++) begin
            rand_img();
            full_frame($sformatf("rnd%0d", f), f % 4, int'($urandom_range(0, 127)));
        end

        // Second start mid-run with different mode/threshold must be ignored.
        rand_img();
        begin_frame(3, 40);
        repeat (7 * P) tick();
        chk("restart_busy_mid", busy, 1);
        mode = 2'd0; thres = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart");
        check_frame("restart", 3, 40);

        rand_img();
        begin_frame(1, 20);
        n = 0;
        while (wq_addr.size() < 5 && n < RUNCYC) begin
            tick();
            n++;
        end
        chk("abort_reached5", wq_addr.size(), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_next", busy, 0);
        repeat (3 * P) tick();
        chk("abort_nwr", wq_addr.size(), 5);
        chk("abort_done", done_cnt, 0);
        chk("abort_busy", busy, 0);
        full_frame("after_abort", 2, 15);

        rand_img();
        begin_frame(0, 3);
        repeat (3 * P + 5) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_we", write_en, 0);
        chk("midrst_wd", write_data, 0);
        chk("midrst_ra", read_addr, 0);
        chk("midrst_wa", write_addr, 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("midrst_nodone", done_cnt, 0);
        full_frame("after_rst", 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
